port_rd_scheduler: RTL and testbench
====================================

PORT_RD_SCHEDULER -- requirements
Module: port_rd_scheduler

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 8, number of per-port priority queues (2..16).
REQ-002 SHALL have parameter WEIGHT_W, default 4, bit width of each WRR weight.
REQ-003 SHALL define local QW = clog2(NUM_QUEUES).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-high (asserted = 1).
REQ-006 mode  in  2  0 strict priority, 1 round robin, 2 WRR, 3 reserved (treated as 0).
REQ-007 weights  in  NUM_QUEUES*WEIGHT_W  queue i weight at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-008 queue_available  in  NUM_QUEUES  bit i = queue i non-empty.
REQ-009 sched_vld  out  1  grant offer valid.
REQ-010 sched_queue  out  QW  offered/active queue index.
REQ-011 sched_rdy  in  1  consumer accepts offer (packet start).
REQ-012 pkt_done  in  1  end of packet on active queue.
REQ-013 busy  out  1  packet in flight.

Function
REQ-014 SHALL implement FSM IDLE, GRANT, BUSY; reset state IDLE.
REQ-015 mode and weights SHALL be sampled only in IDLE; changes during GRANT/BUSY take effect at next IDLE.
REQ-016 IDLE: if any eligible queue, register choice into sched_queue, go GRANT; sched_vld high the next cycle (1-cycle latency).
REQ-017 GRANT: sched_vld=1, sched_queue stable until sched_rdy.
REQ-018 GRANT with sched_rdy=1: go BUSY, busy=1 next cycle, sched_vld=0 next cycle.
REQ-019 GRANT with sched_rdy=0 and queue_available[sched_queue]=0: withdraw, go IDLE, sched_vld=0 next cycle.
REQ-020 sched_rdy and pkt_done in same GRANT cycle: single-word packet, go IDLE directly; credit still charged.
REQ-021 BUSY: on pkt_done go IDLE; pkt_done in IDLE or with sched_rdy=0 in GRANT SHALL be ignored.
REQ-022 Strict priority: lowest-index available queue wins.
REQ-023 Round robin: first available queue searching from (last_granted+1) mod NUM_QUEUES upward with wrap; last_granted reset 0.
REQ-024 WRR: per-queue credit counter, WEIGHT_W bits, reset to 0.
REQ-025 WRR eligible = available AND credit>0; prefer last_granted if eligible, else RR search as REQ-023 over eligible.
REQ-026 WRR: no eligible queue but some available queue with weight>0 -> reload all credits from weights in that IDLE cycle, choose among reloaded set same cycle.
REQ-027 WRR: weight 0 queues SHALL never be granted; all-zero-weight available set -> stay IDLE.
REQ-028 Credit decrements by 1 on acceptance (REQ-018/020), saturating at 0; no arithmetic wrap.
REQ-029 last_granted updates on acceptance only, not on withdrawal.
REQ-030 sched_queue SHALL hold its last value in IDLE/BUSY.

Reset
REQ-031 Reset SHALL force: state IDLE, sched_vld 0, sched_queue 0, busy 0, credits 0, last_granted 0.
REQ-032 Reset mid-GRANT/BUSY SHALL drop the grant with no pkt_done required; outputs at reset values next cycle.

Structure
REQ-033 Mode encodings and FSM state enum SHALL live in shared package hydra_pkg.
REQ-034 One sub-module port_rd_rr_pick SHALL be used: combinational masked rotate-priority search (request vector, start pointer -> index, found).
REQ-035 Strict priority SHALL reuse port_rd_rr_pick with start pointer 0.

Verification
REQ-036 SP: queue_available=0x0A, sched_rdy tied 1 -> sched_queue=1 offered 1 cycle after IDLE.
REQ-037 RR: available=0xFF, each packet one cycle, pkt_done with sched_rdy -> grants 1,2,...,7,0 (wrap).
REQ-038 WRR: weights q0=3, q1=1, others 0, both available -> grant sequence 0,0,0,1,0,0,0,1.
REQ-039 Withdrawal: offer q2, sched_rdy=0, clear bit2 -> sched_vld low next cycle; last_granted unchanged.
REQ-040 Reset mid-BUSY: assert rst_n one cycle -> busy=0, sched_vld=0, credits 0; next offer follows REQ-026 reload.
REQ-041 Mode change 0->1 during BUSY -> current packet completes, next choice uses RR.

Source files
------------

// File: rtl/port_rd_scheduler_pkg.sv
// Shared encodings for the port read scheduler: arbitration modes, FSM states
// and the mode decode that folds the reserved encoding onto strict priority.
package hydra_pkg;

    typedef enum logic [1:0] {
        MODE_SP  = 2'd0,
        MODE_RR  = 2'd1,
        MODE_WRR = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    function automatic mode_e mode_decode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd1:    r = MODE_RR;
            2'd2:    r = MODE_WRR;
            default: r = MODE_SP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/port_rd_scheduler_if.sv
// Grant/packet handshake between the read scheduler (master) and the packet
// reader that consumes its offers (slave).
interface port_rd_scheduler_if #(
    parameter int NUM_QUEUES = 8
) ();
    localparam int QW = $clog2(NUM_QUEUES);

    logic          sched_vld;
    logic [QW-1:0] sched_queue;
    logic          sched_rdy;
    logic          pkt_done;
    logic          busy;

    modport master (
        output sched_vld,
        output sched_queue,
        output busy,
        input  sched_rdy,
        input  pkt_done
    );

    modport slave (
        input  sched_vld,
        input  sched_queue,
        input  busy,
        output sched_rdy,
        output pkt_done
    );
endinterface

// File: rtl/port_rd_scheduler_rr_pick.sv
// Rotating-priority search: first set bit of req at or after start, wrapping
// modulo N. Works for any N in 2..16, not just powers of two.
module port_rd_rr_pick #(
    parameter int N  = 8,
    parameter int QW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [QW-1:0] start,
    output logic [QW-1:0] idx,
    output logic          found
);
    localparam logic [QW:0] N_W = (QW+1)'(N);

    logic [QW:0]   sum_s;
    logic [QW-1:0] cand_s;
    logic          hit_s;

    // Walk the N candidates in rotated order, latching the first requester
    always_comb begin
        idx    = {QW{1'b0}};
        found  = 1'b0;
        sum_s  = {(QW+1){1'b0}};
        cand_s = {QW{1'b0}};
        hit_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum_s  = {1'b0, start} + (QW+1)'(i);
            cand_s = (sum_s >= N_W) ? QW'(sum_s - N_W) : sum_s[QW-1:0];
            hit_s  = !found && req[cand_s];
            idx    = hit_s ? cand_s : idx;
            found  = found | hit_s;
        end
    end
endmodule

// File: rtl/port_rd_scheduler.sv
// Per-port read scheduler: picks one of NUM_QUEUES priority queues by strict
// priority, round robin or weighted round robin and tracks the packet in flight.
module port_rd_scheduler
    import hydra_pkg::*;
#(
    parameter int NUM_QUEUES = 8,
    parameter int WEIGHT_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     mode,
    input  logic [NUM_QUEUES*WEIGHT_W-1:0] weights,
    input  logic [NUM_QUEUES-1:0]          queue_available,
    port_rd_scheduler_if.master            sif
);
    localparam int QW = $clog2(NUM_QUEUES);

    state_e              state_r, state_s;
    mode_e               mode_r, mode_s, mode_eff_s;
    logic                sched_vld_r, sched_vld_s;
    logic                busy_r, busy_s;
    logic                fresh_r, fresh_s;
    logic [QW-1:0]       queue_r, queue_s;
    logic [QW-1:0]       last_r, last_s, last_inc_s;
    logic [WEIGHT_W-1:0] credit_r [NUM_QUEUES];
    logic [WEIGHT_W-1:0] credit_s [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] has_credit_s, has_weight_s, elig_s, reload_set_s;
    logic [NUM_QUEUES-1:0] pick_req_s;
    logic [QW-1:0]         pick_start_s, pick_idx_s, chosen_s;
    logic                  pick_found_s, prefer_last_s, reload_s;

    port_rd_rr_pick #(.N(NUM_QUEUES), .QW(QW)) u_pick (
        .req   (pick_req_s),
        .start (pick_start_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Candidate selection for the IDLE decision, driven by the live mode/weights
    always_comb begin
        mode_eff_s    = mode_decode(mode);
        last_inc_s    = (last_r == QW'(NUM_QUEUES-1)) ? {QW{1'b0}} : last_r + QW'(1);
        for (int i = 0; i < NUM_QUEUES; i++) begin
            has_credit_s[i] = |credit_r[i];
            has_weight_s[i] = |weights[i*WEIGHT_W +: WEIGHT_W];
        end
        elig_s        = queue_available & has_credit_s;
        reload_set_s  = queue_available & has_weight_s;
        pick_req_s    = queue_available;
        pick_start_s  = {QW{1'b0}};
        prefer_last_s = 1'b0;
        reload_s      = 1'b0;
        case (mode_eff_s)
            MODE_RR: begin
                pick_start_s = last_inc_s;
            end
            MODE_WRR: begin
                if (|elig_s) begin
                    pick_req_s    = elig_s;
                    pick_start_s  = last_inc_s;
                    prefer_last_s = elig_s[last_r];
                end else begin
                    // A queue that just drained its credit yields to the next in
                    // rotation; before any grant the pointer itself is the start.
                    pick_req_s   = reload_set_s;
                    pick_start_s = fresh_r ? last_r : last_inc_s;
                    reload_s     = |reload_set_s;
                end
            end
            default: begin
                pick_start_s = {QW{1'b0}};
            end
        endcase
        chosen_s = prefer_last_s ? last_r : pick_idx_s;
    end

    // Next-state and next-output logic for the IDLE/GRANT/BUSY controller
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        sched_vld_s = sched_vld_r;
        busy_s      = busy_r;
        fresh_s     = fresh_r;
        queue_s     = queue_r;
        last_s      = last_r;
        credit_s    = credit_r;
        case (state_r)
            ST_IDLE: begin
                if (reload_s) begin
                    for (int i = 0; i < NUM_QUEUES; i++) begin
                        credit_s[i] = weights[i*WEIGHT_W +: WEIGHT_W];
                    end
                end else begin
                    credit_s = credit_r;
                end
                if (pick_found_s) begin
                    state_s     = ST_GRANT;
                    sched_vld_s = 1'b1;
                    queue_s     = chosen_s;
                    mode_s      = mode_eff_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (sif.sched_rdy) begin
                    sched_vld_s = 1'b0;
                    last_s      = queue_r;
                    fresh_s     = 1'b0;
                    if (mode_r == MODE_WRR && credit_r[queue_r] != {WEIGHT_W{1'b0}}) begin
                        credit_s[queue_r] = credit_r[queue_r] - WEIGHT_W'(1);
                    end else begin
                        credit_s[queue_r] = credit_r[queue_r];
                    end
                    if (sif.pkt_done) begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = ST_BUSY;
                        busy_s  = 1'b1;
                    end
                end else if (!queue_available[queue_r]) begin
                    state_s     = ST_IDLE;
                    sched_vld_s = 1'b0;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_BUSY: begin
                if (sif.pkt_done) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                sched_vld_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State, output and credit registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_SP;
            sched_vld_r <= 1'b0;
            busy_r      <= 1'b0;
            fresh_r     <= 1'b1;
            queue_r     <= {QW{1'b0}};
            last_r      <= {QW{1'b0}};
            for (int i = 0; i < NUM_QUEUES; i++) begin
                credit_r[i] <= {WEIGHT_W{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            sched_vld_r <= sched_vld_s;
            busy_r      <= busy_s;
            fresh_r     <= fresh_s;
            queue_r     <= queue_s;
            last_r      <= last_s;
            credit_r    <= credit_s;
        end
    end

    assign sif.sched_vld   = sched_vld_r;
    assign sif.sched_queue = queue_r;
    assign sif.busy        = busy_r;
endmodule

// File: tb/tb_port_rd_scheduler.sv
// Directed bench for port_rd_scheduler: stimulus pushes the expected queue of
// every grant it will accept; a monitor pops and compares on each acceptance.
module tb_port_rd_scheduler;
    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [31:0] weights;
    logic [7:0]  avail;

    int vectors;
    int miscompares;
    logic [2:0] exp_q[$];

    port_rd_scheduler_if #(.NUM_QUEUES(8)) sif ();

    port_rd_scheduler #(.NUM_QUEUES(8), .WEIGHT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mode            (mode),
        .weights         (weights),
        .queue_available (avail),
        .sif             (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted offer must match the next expected queue
    always @(negedge clk) begin
        if (!rst_n && sif.sched_vld && sif.sched_rdy) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL grant: unexpected grant of queue %0d, required none", sif.sched_queue);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (sif.sched_queue !== e) begin
                    miscompares++;
                    $display("FAIL grant: got queue %0d, required %0d", sif.sched_queue, e);
                end
            end
        end
    end

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (sif.sched_vld === 1'b1);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_vld: sched_vld stayed 0 for 20 cycles, required 1");
        end
    endtask

    task automatic accept_one(input bit done, input logic [2:0] exp);
        bit ok;
        exp_q.push_back(exp);
        wait_vld(ok);
        if (ok) begin
            sif.sched_rdy = 1'b1;
            sif.pkt_done  = done;
            @(posedge clk); #1;
            sif.sched_rdy = 1'b0;
            sif.pkt_done  = 1'b0;
        end else begin
            void'(exp_q.pop_back());
        end
    endtask

    task automatic do_reset();
        sif.sched_rdy = 1'b0;
        sif.pkt_done  = 1'b0;
        avail         = 8'h00;
        rst_n         = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit ok;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b1;
        mode          = 2'd0;
        weights       = 32'h0000_0000;
        avail         = 8'h00;
        sif.sched_rdy = 1'b0;
        sif.pkt_done  = 1'b0;
        idle_cycles(2);
        check("rst_vld", {31'd0, sif.sched_vld}, 32'd0);
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_queue", {29'd0, sif.sched_queue}, 32'd0);
        rst_n = 1'b0;

        // Strict priority, ready tied high: queue 1 offered one cycle later
        mode = 2'd0;
        exp_q.push_back(3'd1);
        avail = 8'h0A; sif.sched_rdy = 1'b1; sif.pkt_done = 1'b1;
        idle_cycles(1);
        check("sp_latency_vld", {31'd0, sif.sched_vld}, 32'd1);
        check("sp_queue", {29'd0, sif.sched_queue}, 32'd1);
        idle_cycles(1);
        avail = 8'h00; sif.sched_rdy = 1'b0; sif.pkt_done = 1'b0;
        check("sp_vld_drop", {31'd0, sif.sched_vld}, 32'd0);

        // Round robin from reset pointer 0: 1..7 then wrap to 0
        do_reset();
        mode = 2'd1; avail = 8'hFF;
        for (int i = 0; i < 8; i++) accept_one(1'b1, 3'((i + 1) % 8));

        // WRR q0=3, q1=1: 0,0,0,1,0,0,0,1
        do_reset();
        mode = 2'd2; weights = 32'h0000_0013; avail = 8'h03;
        accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd1);
        accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd1);

        // WRR with only zero-weight queues available stays idle
        do_reset();
        mode = 2'd2; weights = 32'h0000_0000; avail = 8'h0C;
        idle_cycles(4);
        check("wrr_zero_weight_idle", {31'd0, sif.sched_vld}, 32'd0);
        // Only q5 weighted: everything else available is never granted
        weights = 32'h0020_0000; avail = 8'hFF;
        accept_one(1'b1, 3'd5); accept_one(1'b1, 3'd5); accept_one(1'b1, 3'd5);

        // pkt_done ignored in IDLE and in GRANT without ready; then withdrawal
        do_reset();
        mode = 2'd0;
        sif.pkt_done = 1'b1; idle_cycles(1); sif.pkt_done = 1'b0;
        check("done_in_idle_busy", {31'd0, sif.busy}, 32'd0);
        avail = 8'h04;
        wait_vld(ok);
        check("wd_offer_queue", {29'd0, sif.sched_queue}, 32'd2);
        sif.pkt_done = 1'b1; idle_cycles(1); sif.pkt_done = 1'b0;
        check("done_in_grant_vld", {31'd0, sif.sched_vld}, 32'd1);
        check("done_in_grant_busy", {31'd0, sif.busy}, 32'd0);
        avail = 8'h00;
        idle_cycles(1);
        check("wd_vld_drop", {31'd0, sif.sched_vld}, 32'd0);
        // last_granted still 0 after withdrawal, so RR over {1,3} picks 1
        mode = 2'd1; avail = 8'h0A;
        accept_one(1'b1, 3'd1);

        // Reset in the middle of a WRR packet clears credits and pointer
        do_reset();
        mode = 2'd2; weights = 32'h0000_0013; avail = 8'h03;
        accept_one(1'b1, 3'd0); accept_one(1'b1, 3'd0); accept_one(1'b0, 3'd0);
        check("busy_set", {31'd0, sif.busy}, 32'd1);
        rst_n = 1'b1; idle_cycles(1); rst_n = 1'b0;
        check("midrst_busy", {31'd0, sif.busy}, 32'd0);
        check("midrst_vld", {31'd0, sif.sched_vld}, 32'd0);
        check("midrst_queue", {29'd0, sif.sched_queue}, 32'd0);
        accept_one(1'b1, 3'd0);

        // Mode change during BUSY waits for the packet, then RR applies
        do_reset();
        mode = 2'd0; avail = 8'h03;
        accept_one(1'b0, 3'd0);
        mode = 2'd1;
        idle_cycles(2);
        check("busy_hold", {31'd0, sif.busy}, 32'd1);
        check("busy_no_offer", {31'd0, sif.sched_vld}, 32'd0);
        sif.pkt_done = 1'b1; idle_cycles(1); sif.pkt_done = 1'b0;
        check("busy_release", {31'd0, sif.busy}, 32'd0);
        accept_one(1'b1, 3'd1);

        idle_cycles(2);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
